ctrlread_req_arbiter: RTL and testbench
=======================================

# ctrlread_req_arbiter

Round-robin arbiter that shares the single control-read request FIFO (`fifo_ctrlread_req`, `RequestItem_t` entries) between up to `NUM_REQ` independent requesters. It sits directly in front of the FIFO write port: it grants one requester at a time, lets it push a bounded burst of requests, and releases the grant, giving fair, burst-bounded access. The FIFO read side and the FIFO itself are outside this block.

## Interface
- `NUM_REQ`, 4: number of requesters, 2..8.
- `REQ_WIDTH`, `$bits(RequestItem_t)`: request item width; must equal the FIFO `INPUT_WIDTH`.
- `BURST_MAX`, 4: maximum accepted items per grant, 1..16.

Ports:
- `clk` in 1: single clock; all logic rising-edge.
- `srst` in 1: synchronous, active-high reset.
- `req_valid` in `NUM_REQ`: requester i holds a request item.
- `req_data` in `NUM_REQ*REQ_WIDTH`: item of requester i at bits `[i*REQ_WIDTH +: REQ_WIDTH]`.
- `req_ready` out `NUM_REQ`: item of requester i accepted this cycle when `req_valid[i] & req_ready[i]`.
- `fifo_din` out `REQ_WIDTH`: to FIFO `din`.
- `fifo_wr_en` out 1: to FIFO `wr_en`.
- `fifo_full` in 1: from FIFO `full`.
- `fifo_wr_rst_busy` in 1: from FIFO `wr_rst_busy`; blocks writes like full.
- `grant_valid` out 1: a requester currently owns the FIFO.
- `grant_id` out `$clog2(NUM_REQ)`: current owner index.

## Operation
- FSM states IDLE, BUSY. Registered: `state`, `grant_id`, `rr_ptr`, `burst_cnt` (width `$clog2(BURST_MAX)+1`).
- IDLE: if any `req_valid`, pick the first asserted index scanning `rr_ptr, rr_ptr+1, …` modulo `NUM_REQ`; load `grant_id`, clear `burst_cnt`, go BUSY. No item is accepted in IDLE.
- BUSY: `can_wr = !fifo_full & !fifo_wr_rst_busy`. `req_ready[grant_id] = can_wr`; all other `req_ready` bits 0.
- Transfer = `req_valid[grant_id] & can_wr`; then `fifo_wr_en=1`, `fifo_din` = owner's slice, `burst_cnt` += 1.
- Release (go IDLE, `rr_ptr = grant_id+1` mod `NUM_REQ`) when: transfer with `burst_cnt == BURST_MAX-1`, or `req_valid[grant_id]==0` (owner has drained).
- Stall on `can_wr==0`: owner keeps grant, `burst_cnt` unchanged; stall never causes release.
- `fifo_wr_en` never asserts with `fifo_full` or `fifo_wr_rst_busy` high (never write a full FIFO).
- `fifo_din` = owner's slice whenever BUSY, else 0.
- Requesters must hold `req_valid`/`req_data` stable until accepted; dropping valid before acceptance releases the grant.

## Timing
- Reset values: `state`=IDLE, `grant_id`=0, `rr_ptr`=0, `burst_cnt`=0, `req_ready`=0, `fifo_wr_en`=0, `fifo_din`=0, `grant_valid`=0.
- `srst` mid-burst: next cycle all outputs at reset values; partially sent burst is not resumed; no write in the reset cycle.
- Grant latency: first item of a grant accepted ≥1 cycle after valid seen in IDLE.
- `req_ready`, `fifo_wr_en`, `fifo_din` are combinational from registered state plus `req_valid`, `fifo_full`, `fifo_wr_rst_busy`; no data register (zero-latency pass-through).
- One bubble cycle (IDLE) between consecutive grants. Sustained throughput: `BURST_MAX` items per `BURST_MAX+1` cycles.
- `grant_valid` = (state==BUSY), registered.

## Configuration
- `CTRLREAD_ARB_STATS_EN` defined: adds input `stats_clr` (1) and output `grant_cnt` (`NUM_REQ*16`). Per-requester 16-bit counter increments on every accepted item, saturates at 0xFFFF, and is cleared by `srst` or `stats_clr` (clear wins over increment in the same cycle).
- Undefined: ports and counters absent; arbitration behaviour identical.

## Test plan
- Single requester: `NUM_REQ`=4, `BURST_MAX`=4, req 2 holds 6 items -> grant at cycle 1, items 0..3 written cycles 1..4, IDLE cycle 5, items 4..5 written cycles 6..7; `rr_ptr`=3 after each release.
- Fairness: all 4 requesters continuously valid, `BURST_MAX`=2 -> grant order 0,1,2,3,0,…; each burst exactly 2 writes; 1 bubble between grants.
- Backpressure: `fifo_full` high 3 cycles mid-burst -> `fifo_wr_en`=0 and `req_ready`=0 for those 3 cycles, grant kept, burst resumes with `burst_cnt` unchanged.
- `fifo_wr_rst_busy` high after reset for 5 cycles with req 1 valid -> zero writes until it falls, then normal transfer.
- Early drop: owner 3 sends 1 item then deasserts valid with `BURST_MAX`=4 -> release next cycle, `rr_ptr`=0, requester 0 granted next.
- `srst` pulsed mid-burst (with `CTRLREAD_ARB_STATS_EN`): all outputs at reset values next cycle, `grant_cnt` all 0; `stats_clr` alone zeroes counters without disturbing the grant.

Source files
------------

// File: rtl/ctrlread_req_arbiter.sv
// ctrlread_req_arbiter: round-robin, burst-bounded write-port arbiter for fifo_ctrlread_req; define CTRLREAD_ARB_STATS_EN for per-requester accept counters
module ctrlread_req_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int REQ_WIDTH = 32,
    parameter int BURST_MAX = 4
) (
    input  logic                         clk,
    input  logic                         srst,
    input  logic [NUM_REQ-1:0]           req_valid,
    input  logic [NUM_REQ*REQ_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]           req_ready,
    output logic [REQ_WIDTH-1:0]         fifo_din,
    output logic                         fifo_wr_en,
    input  logic                         fifo_full,
    input  logic                         fifo_wr_rst_busy,
`ifdef CTRLREAD_ARB_STATS_EN
    input  logic                         stats_clr,
    output logic [NUM_REQ*16-1:0]        grant_cnt,
`endif
    output logic                         grant_valid,
    output logic [$clog2(NUM_REQ)-1:0]   grant_id
);
    localparam int IW = $clog2(NUM_REQ);
    localparam int CW = $clog2(BURST_MAX) + 1;
    localparam logic [CW-1:0] LAST = CW'(BURST_MAX - 1);
    localparam logic [IW:0] NR = (IW + 1)'(NUM_REQ);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t               state, state_d;
    logic [IW-1:0]        rr_ptr, rr_d, grant_d, pick, next_id;
    logic [CW-1:0]        burst_cnt, burst_d;
    logic [IW:0]          scan;
    logic [REQ_WIDTH-1:0] slice [NUM_REQ];
    logic                 found, busy, can_wr, owner_valid, xfer, release_grant;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_slice
        assign slice[g] = req_data[g*REQ_WIDTH +: REQ_WIDTH];
    end

    // reset also blocks writes so nothing lands in the FIFO during the reset cycle
    assign busy          = state == BUSY;
    assign can_wr        = !fifo_full && !fifo_wr_rst_busy && !srst;
    assign owner_valid   = req_valid[grant_id];
    assign xfer          = busy && owner_valid && can_wr;
    assign release_grant = busy && (!owner_valid || (xfer && burst_cnt == LAST));
    assign next_id       = (grant_id == IW'(NUM_REQ - 1)) ? '0 : grant_id + IW'(1);

    // scanned from the far end so the index closest to rr_ptr wins
    always_comb begin
        pick  = rr_ptr;
        found = 1'b0;
        scan  = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            scan = {1'b0, rr_ptr} + (IW + 1)'(k);
            scan = (scan >= NR) ? scan - NR : scan;
            if (req_valid[scan[IW-1:0]]) begin
                pick  = scan[IW-1:0];
                found = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            state     <= IDLE;
            grant_id  <= '0;
            rr_ptr    <= '0;
            burst_cnt <= '0;
        end else begin
            state     <= state_d;
            grant_id  <= grant_d;
            rr_ptr    <= rr_d;
            burst_cnt <= burst_d;
        end
    end

    always_comb begin
        state_d = busy ? (release_grant ? IDLE : BUSY) : (found ? BUSY : IDLE);
        grant_d = (!busy && found) ? pick : grant_id;
        rr_d    = release_grant ? next_id : rr_ptr;
        burst_d = !busy ? '0 : (xfer ? burst_cnt + CW'(1) : burst_cnt);
    end

    always_comb begin
        grant_valid = busy;
        req_ready   = (busy && can_wr) ? (NUM_REQ'(1) << grant_id) : '0;
        fifo_wr_en  = xfer;
        fifo_din    = busy ? slice[grant_id] : '0;
    end

`ifdef CTRLREAD_ARB_STATS_EN
    for (genvar g = 0; g < NUM_REQ; g++) begin : g_stats
        logic [15:0] cnt;
        always_ff @(posedge clk) begin
            if (srst || stats_clr)
                cnt <= '0;
            else if (req_valid[g] && req_ready[g] && cnt != 16'hFFFF)
                cnt <= cnt + 16'd1;
        end
        assign grant_cnt[g*16 +: 16] = cnt;
    end
`endif
endmodule

// File: tb/tb_ctrlread_req_arbiter.sv
// tb_ctrlread_req_arbiter: directed vectors with a write scoreboard for ctrlread_req_arbiter
module tb_ctrlread_req_arbiter;
    localparam int N  = 4;
    localparam int W  = 32;
    localparam int BM = 4;

    logic           clk = 1'b0;
    logic           srst = 1'b1;
    logic           fifo_full = 1'b0;
    logic           fifo_wr_rst_busy = 1'b0;
    logic [N-1:0]   req_valid, req_ready;
    logic [N-1:0]   acc = '0;
    logic [N*W-1:0] req_data;
    logic [W-1:0]   fifo_din;
    logic           fifo_wr_en, grant_valid;
    logic [1:0]     grant_id;
`ifdef CTRLREAD_ARB_STATS_EN
    logic            stats_clr = 1'b0;
    logic [N*16-1:0] grant_cnt;
`endif

    logic [W-1:0] items [N][64];
    int           head [N];
    int           tail [N];
    logic [W-1:0] exp_d [$];
    int           exp_c [$];
    int           cyc = 0;
    int           n_cmp = 0;
    int           n_bad = 0;
    int           t0, b, b2;

    ctrlread_req_arbiter #(.NUM_REQ(N), .REQ_WIDTH(W), .BURST_MAX(BM)) dut (
        .clk(clk),
        .srst(srst),
        .req_valid(req_valid),
        .req_data(req_data),
        .req_ready(req_ready),
        .fifo_din(fifo_din),
        .fifo_wr_en(fifo_wr_en),
        .fifo_full(fifo_full),
        .fifo_wr_rst_busy(fifo_wr_rst_busy),
`ifdef CTRLREAD_ARB_STATS_EN
        .stats_clr(stats_clr),
        .grant_cnt(grant_cnt),
`endif
        .grant_valid(grant_valid),
        .grant_id(grant_id)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] want);
        n_cmp++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, want, cyc);
        end
    endfunction

    function automatic logic [W-1:0] mk(input int id, input int idx);
        return {8'(id), 8'hC3, 16'(idx)};
    endfunction

    // requester models: each holds its queue head until accepted
    always_comb begin
        req_valid = '0;
        req_data  = '0;
        for (int i = 0; i < N; i++) begin
            req_valid[i]        = head[i] != tail[i];
            req_data[i*W +: W]  = items[i][head[i][5:0]];
        end
    end
    always @(negedge clk) acc <= req_valid & req_ready;
    always @(posedge clk)
        for (int i = 0; i < N; i++)
            if (acc[i]) head[i] <= head[i] + 1;

    always @(negedge clk) begin : mon
        int c;
        if (fifo_wr_en === 1'b1) begin
            check("wr_blocked", {30'b0, fifo_full, fifo_wr_rst_busy}, 0);
            check("wr_expected", 32'(exp_d.size() != 0), 1);
            if (exp_d.size() != 0) begin
                check("wr_data", fifo_din, exp_d.pop_front());
                c = exp_c.pop_front();
                check("wr_cycle", 32'(cyc), 32'(c));
            end
        end
    end

    task automatic load(input int id, input int n);
        for (int k = 0; k < n; k++) begin
            items[id][tail[id]] = mk(id, tail[id]);
            tail[id]++;
        end
    endtask

    task automatic expect_wr(input int id, input int idx, input int c);
        exp_d.push_back(mk(id, idx));
        exp_c.push_back(c);
    endtask

    function automatic logic pending();
        for (int i = 0; i < N; i++)
            if (head[i] != tail[i]) return 1'b1;
        return 1'b0;
    endfunction

    task automatic drain(input string name);
        int bud = 0;
        while ((exp_d.size() != 0 || pending() || grant_valid) && bud < 300) begin
            @(negedge clk);
            bud++;
        end
        check({name, "_sb"}, 32'(exp_d.size()), 0);
        check({name, "_idle"}, grant_valid, 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_gv", grant_valid, 0);
        check("rst_id", grant_id, 0);
        check("rst_rdy", req_ready, 0);
        check("rst_wr", fifo_wr_en, 0);
        check("rst_din", fifo_din, 0);
        // wr_rst_busy holds off req 1 for five cycles
        @(posedge clk); #1;
        srst = 1'b0;
        fifo_wr_rst_busy = 1'b1;
        t0 = cyc; b = tail[1];
        load(1, 2);
        expect_wr(1, b, t0 + 6);
        expect_wr(1, b + 1, t0 + 7);
        for (int k = 1; k <= 5; k++) begin
            @(posedge clk);
            @(negedge clk);
            check("rstbusy_wr", fifo_wr_en, 0);
            check("rstbusy_gv", grant_valid, 1);
        end
        @(posedge clk); #1;
        fifo_wr_rst_busy = 1'b0;
        drain("rstbusy");
        // single requester 2 with 6 items: 4-item burst, bubble, 2 items
        t0 = cyc; b = tail[2];
        load(2, 6);
        for (int k = 0; k < 6; k++) expect_wr(2, b + k, t0 + 1 + k + (k >= 4 ? 1 : 0));
        drain("single");
        // all four busy: rr_ptr is 3, so order 3,0,1,2
        t0 = cyc;
        for (int o = 0; o < N; o++) begin
            b = tail[(3 + o) % N];
            load((3 + o) % N, BM);
            for (int k = 0; k < BM; k++) expect_wr((3 + o) % N, b + k, t0 + 1 + 5 * o + k);
        end
        drain("fair");
        // full for three cycles mid-burst on requester 0
        t0 = cyc; b = tail[0];
        load(0, 4);
        expect_wr(0, b, t0 + 1);
        expect_wr(0, b + 1, t0 + 2);
        expect_wr(0, b + 2, t0 + 6);
        expect_wr(0, b + 3, t0 + 7);
        repeat (3) @(posedge clk);
        #1;
        fifo_full = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("bp_wr", fifo_wr_en, 0);
            check("bp_rdy", req_ready, 0);
            check("bp_gv", grant_valid, 1);
            check("bp_id", grant_id, 0);
            @(posedge clk);
        end
        #1;
        fifo_full = 1'b0;
        drain("bp");
        // move rr_ptr to 3, then owner 3 drops after one item
        t0 = cyc; b = tail[2];
        load(2, 1);
        expect_wr(2, b, t0 + 1);
        drain("pre_drop");
        t0 = cyc;
        expect_wr(3, tail[3], t0 + 1);
        expect_wr(0, tail[0], t0 + 4);
        expect_wr(1, tail[1], t0 + 7);
        load(3, 1);
        load(0, 1);
        load(1, 1);
        drain("drop");
        // reset in the middle of requester 1's burst
        t0 = cyc; b = tail[1];
        load(1, 4);
        expect_wr(1, b, t0 + 1);
        expect_wr(1, b + 1, t0 + 2);
        repeat (3) @(posedge clk);
        #1;
        srst = 1'b1;
        b2 = tail[2];
        load(2, 1);
        expect_wr(2, b2, t0 + 5);
        @(negedge clk);
        check("srst_wr", fifo_wr_en, 0);
        check("srst_rdy", req_ready, 0);
        tail[1] = head[1];
        @(posedge clk); #1;
        srst = 1'b0;
        @(negedge clk);
        check("post_rst_gv", grant_valid, 0);
        check("post_rst_id", grant_id, 0);
        check("post_rst_rdy", req_ready, 0);
        check("post_rst_wr", fifo_wr_en, 0);
        check("post_rst_din", fifo_din, 0);
`ifdef CTRLREAD_ARB_STATS_EN
        check("post_rst_cnt_lo", grant_cnt[31:0], 0);
        check("post_rst_cnt_hi", grant_cnt[63:32], 0);
`endif
        @(posedge clk); #1;
        drain("srst");
`ifdef CTRLREAD_ARB_STATS_EN
        check("cnt2_after", grant_cnt[47:32], 1);
        t0 = cyc; b = tail[0];
        load(0, 3);
        for (int k = 0; k < 3; k++) expect_wr(0, b + k, t0 + 1 + k);
        repeat (2) @(posedge clk);
        #1;
        stats_clr = 1'b1;
        @(negedge clk);
        check("clr_gv", grant_valid, 1);
        check("clr_id", grant_id, 0);
        @(posedge clk); #1;
        stats_clr = 1'b0;
        drain("stats");
        check("cnt0_after_clr", grant_cnt[15:0], 1);
        check("cnt2_after_clr", grant_cnt[47:32], 0);
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
